// File: rtl/chat_filter.sv
// chat_filter: chattering (debounce) filter for one noisy 1-bit input.
// A new input level reaches `out` only after STABLE_CYCLES consecutive
// samples of that level. Shorter pulses and glitches are discarded.
//
// Build option (macro CHAT_EDGE_EN):
//   defined   -> adds registered one-cycle `rise` / `fall` pulses that are
//                aligned with the cycle where `out` first shows its new level
//   undefined -> only `out` is present; `out` behaves the same in both builds
//
// Reset: `rst` is asynchronous and active-low. All flops clear to 0.
module chat_filter #(
  parameter int STABLE_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
`ifdef CHAT_EDGE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  // The counter only has to reach STABLE_CYCLES-1, so it never wraps.
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             in_q;
  logic             in_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             out_q;
  logic             out_d;

  // Qualification: count samples that differ from out; any matching sample restarts the count.
  always_comb begin
    in_d  = in;
    cnt_d = cnt_q;
    out_d = out_q;
    if (in_q == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      out_d = in_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Sample stage, counter and filtered output, all cleared by the async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_q  <= 1'b0;
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      in_q  <= in_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

`ifdef CHAT_EDGE_EN
  logic rise_q;
  logic rise_d;
  logic fall_q;
  logic fall_d;

  // Edge pulses are computed from the next output so they line up with the new out level.
  always_comb begin
    rise_d = out_d & ~out_q;
    fall_d = ~out_d & out_q;
  end

  // Edge pulse registers; low during reset and in the first cycle after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

endmodule

// File: tb/tb_chat_filter.sv
// Bench for chat_filter: STABLE_CYCLES=3 and STABLE_CYCLES=1 instances
// against a window-based reference model, plus directed scenarios.
module tb_chat_filter;

  logic clk;
  logic rst;
  logic in3;
  logic in1;
  logic out3;
  logic out1;
`ifdef CHAT_EDGE_EN
  logic rise3, fall3, rise1, fall1;
`endif

  int total = 0;
  int bad   = 0;

  chat_filter #(.STABLE_CYCLES(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .in  (in3),
    .out (out3)
`ifdef CHAT_EDGE_EN
    ,
    .rise(rise3),
    .fall(fall3)
`endif
  );

  chat_filter #(.STABLE_CYCLES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .in  (in1),
    .out (out1)
`ifdef CHAT_EDGE_EN
    ,
    .rise(rise1),
    .fall(fall1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: out flips when the last S registered samples all
  // differ from the current out.
  logic [7:0] h3, h1;
  logic       iq3, iq1, o3, o1, r3m, f3m, r1m, f1m;

  task automatic reset_models();
    h3 = '0; iq3 = 1'b0; o3 = 1'b0; r3m = 1'b0; f3m = 1'b0;
    h1 = '0; iq1 = 1'b0; o1 = 1'b0; r1m = 1'b0; f1m = 1'b0;
  endtask

  task automatic model_edge(input int s, input logic din, inout logic [7:0] hist,
                            inout logic inq, inout logic outm, output logic r, output logic f);
    logic all_new;
    all_new = 1'b1;
    hist = {hist[6:0], inq};
    for (int i = 0; i < s; i++)
      if (hist[i] == outm) all_new = 1'b0;
    r = 1'b0;
    f = 1'b0;
    if (all_new) begin
      outm = ~outm;
      r = outm;
      f = ~outm;
    end
    inq = din;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: advance models, check both DUTs #1 after the edge, new random in1.
  task automatic step();
    @(posedge clk);
    if (!rst) reset_models();
    else begin
      model_edge(3, in3, h3, iq3, o3, r3m, f3m);
      model_edge(1, in1, h1, iq1, o1, r1m, f1m);
    end
    #1;
    chk("out3_model", out3, o3);
    chk("out1_model", out1, o1);
`ifdef CHAT_EDGE_EN
    chk("rise3_model", rise3, r3m);
    chk("fall3_model", fall3, f3m);
    chk("rise1_model", rise1, r1m);
    chk("fall1_model", fall1, f1m);
`endif
    in1 = 1'($urandom_range(0, 1));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  int   fall_cnt;

  initial begin
    rst = 1'b0;
    in3 = 1'b0;
    in1 = 1'b0;
    reset_models();
    #1;
    chk("rst_out3", out3, 0);
    chk("rst_cnt3", dut3.cnt_q, 0);
    chk("rst_out1", out1, 0);
    run(3);

    // Release reset, hold in=1: out rises on the 4th edge counting the sampling edge.
    rst = 1'b1;
    in3 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t1_out", out3, (i == 4) ? 8'd1 : 8'd0);
    end
`ifdef CHAT_EDGE_EN
    chk("t1_rise", rise3, 1);
`endif
    run(2);

    // out=1, hold in=0 for 7 cycles: out falls on the 4th edge, a single fall pulse.
    in3 = 1'b0;
    fall_cnt = 0;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("t4_out", out3, (i >= 4) ? 8'd0 : 8'd1);
`ifdef CHAT_EDGE_EN
      if (fall3 === 1'b1) fall_cnt++;
`endif
    end
`ifdef CHAT_EDGE_EN
    chk("t4_fall_once", 8'(fall_cnt), 1);
`endif

    // Alternating input never qualifies.
    for (int i = 0; i < 12; i++) begin
      in3 = (i % 2 == 0);
      step();
      chk("t2_out", out3, 0);
      chk("t2_cnt_lt2", 8'(dut3.cnt_q < 2), 1);
    end
    in3 = 1'b0;
    run(3);

    // 1,1,0,1,1,1 then hold: only the final run of three qualifies.
    for (int j = 0; j < 9; j++) begin
      in3 = (j < 6) ? pat[j] : 1'b1;
      step();
      chk("t3_out", out3, (j >= 6) ? 8'd1 : 8'd0);
    end

    // out=1, cnt=2, then asynchronous reset mid-cycle.
    in3 = 1'b0;
    run(3);
    chk("t5_cnt_pre", dut3.cnt_q, 2);
    chk("t5_out_pre", out3, 1);
    #3;
    rst = 1'b0;
    reset_models();
    #1;
    chk("t5_out_async", out3, 0);
    chk("t5_cnt_async", dut3.cnt_q, 0);
    chk("t5_out1_async", out1, 0);
    step();
    rst = 1'b1;
    in3 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t5_requal", out3, (i == 4) ? 8'd1 : 8'd0);
    end

    // Random stimulus; in1 is random every cycle throughout.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) in3 = ~in3;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
